aes_iter_core: RTL

AES_ITER_CORE -- requirements
Module: aes_iter_core

---
 rtl/aes_pkg.sv | 63 ++++++
 rtl/aes_round_comb.sv | 25 ++
 rtl/aes_iter_core.sv | 100 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES primitives: GF(2^8) helpers, S-box, Rcon, MixColumns and the core's FSM encoding.
package aes_pkg;

   typedef logic [1:0] aes_state_t;
   localparam aes_state_t IDLE = 2'd0;
   localparam aes_state_t RUN  = 2'd1;
   localparam aes_state_t DONE = 2'd2;

   localparam logic [0:9][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   function automatic int aes_nr(input int key_bits);
      return key_bits / 32 + 6;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Inverse as a^254 (square-and-multiply), then the FIPS-197 affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = gf_mul(a, a);
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         inv = gf_mul(inv, sq);
         sq  = gf_mul(sq, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      return (idx >= 4'd1 && idx <= 4'd10) ? RCON[idx - 4'd1] : 8'h00;
   endfunction

   function automatic logic [31:0] mixcol(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_comb import aes_pkg::*; (
   input  logic [127:0] state,
   input  logic [127:0] round_key,
   input  logic         final_round,
   output logic [127:0] next_state
);

   logic [7:0]   sb [16];
   logic [127:0] sr;
   logic [127:0] mc;

   always_comb begin
      sr = '0;
      mc = '0;
      for (int n = 0; n < 16; n++) sb[n] = sbox(state[127-8*n -: 8]);
      // byte index is 4*column + row; row r rotates left by r columns
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[127-8*(4*c+r) -: 8] = sb[4*((c+r)%4) + r];
      for (int c = 0; c < 4; c++) mc[127-32*c -: 32] = mixcol(sr[127-32*c -: 32]);
      next_state = (final_round ? sr : mc) ^ round_key;
   end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES encryptor: one round per clock, round keys expanded on the fly.
module aes_iter_core import aes_pkg::*; #(
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [127:0]        in_state,
   input  logic [KEY_BITS-1:0] in_key,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [127:0]        out_data
);

   localparam int NK = KEY_BITS / 32;
   localparam int NR = aes_nr(KEY_BITS);

   if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
      $error("aes_iter_core: KEY_BITS must be 128, 192 or 256");
   end

   aes_state_t          fsm;
   logic [3:0]          rnd;
   logic [127:0]        st;
   logic [KEY_BITS-1:0] kreg;
   logic [KEY_BITS-1:0] kreg_nxt;
   logic [127:0]        rkey;
   logic [127:0]        nxt;

   assign in_ready  = (fsm == IDLE) || (fsm == DONE && out_ready);
   assign out_valid = (fsm == DONE);
   assign out_data  = st;

   // kreg holds words w[4r-4 .. 4r-5+NK]; extend it by the next four words and
   // take positions 4..7 as this round's key. Only one of the four new words
   // can need SubWord, and the words before it are a plain XOR prefix, so the
   // single SubWord input is formed without a combinational chain through it.
   always_comb begin
      logic [31:0] w [NK+4];
      logic [31:0] acc;
      logic [31:0] sw;
      logic        rot;
      int          base;
      int          pos;
      int          idx;
      kreg_nxt = '0;
      base = 4 * int'(rnd) - 4 + NK;
      pos  = 4;
      rot  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if ((base + k) % NK == 0) begin
            pos = k;
            rot = 1'b1;
         end else if (NK == 8 && (base + k) % 8 == 4) begin
            pos = k;
            rot = 1'b0;
         end
      end
      for (int j = 0; j < NK; j++) w[j] = kreg[KEY_BITS-1-32*j -: 32];
      acc = w[NK-1];
      for (int k = 0; k < 3; k++) if (k < pos) acc = acc ^ w[k];
      sw  = subword(rot ? {acc[23:0], acc[31:24]} : acc);
      idx = (base + pos) / NK;
      for (int k = 0; k < 4; k++)
         w[NK+k] = w[k] ^ ((k == pos) ? (sw ^ {(rot ? rcon(4'(idx)) : 8'h00), 24'h0})
                                      : w[NK+k-1]);
      rkey = {w[4], w[5], w[6], w[7]};
      for (int j = 0; j < NK; j++) kreg_nxt[KEY_BITS-1-32*j -: 32] = w[j+4];
   end

   aes_round_comb u_round (
      .state       (st),
      .round_key   (rkey),
      .final_round (rnd == 4'(NR)),
      .next_state  (nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm  <= IDLE;
         rnd  <= '0;
         st   <= '0;
         kreg <= '0;
      end else if (in_valid && in_ready) begin
         fsm  <= RUN;
         rnd  <= 4'd1;
         st   <= in_state ^ in_key[KEY_BITS-1 -: 128];
         kreg <= in_key;
      end else if (fsm == RUN) begin
         st   <= nxt;
         kreg <= kreg_nxt;
         rnd  <= rnd + 4'd1;
         if (rnd == 4'(NR)) fsm <= DONE;
      end else if (fsm == DONE && out_ready) begin
         fsm <= IDLE;
      end
   end

endmodule
